// File: rtl/debug_trigger.sv
// Two-stage mask/value trigger sequencer feeding a logic-analyser capture block.
// Stage A arms, stage B counts qualified matches, then one trigger pulse per enable session.
module debug_trigger #(
    parameter int N    = 128,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    indata,
    input  logic            enable,
    input  logic [N-1:0]    maska,
    input  logic [N-1:0]    valuea,
    input  logic [N-1:0]    maskb,
    input  logic [N-1:0]    valueb,
    input  logic            edgeb,
    input  logic [CNTW-1:0] count,
    output logic            trigger,
    output logic [N-1:0]    dataout,
    output logic [1:0]      state
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WAITA = 2'd1;
    localparam logic [1:0] WAITB = 2'd2;
    localparam logic [1:0] FIRED = 2'd3;

    logic [N-1:0]    din_reg;
    logic [N-1:0]    dout_reg;
    logic            mb_prev_reg;
    logic [1:0]      state_reg;
    logic [1:0]      state_next;
    logic [CNTW-1:0] cnt_reg;
    logic [CNTW-1:0] cnt_next;
    logic            trig_reg;
    logic            trig_next;

    logic [N-1:0]    miss_a;
    logic [N-1:0]    miss_b;
    logic            ma;
    logic            mb;
    logic            evb;
    logic [CNTW:0]   cnt_inc;
    logic            cnt_hit;
    logic            count_zero;

    // A bit "misses" when it is compared (mask=1) and differs from the value.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_match
            assign miss_a[gi] = maska[gi] & (din_reg[gi] ^ valuea[gi]);
            assign miss_b[gi] = maskb[gi] & (din_reg[gi] ^ valueb[gi]);
        end
    endgenerate

    assign ma  = ~|miss_a;
    assign mb  = ~|miss_b;
    assign evb = mb & (~edgeb | ~mb_prev_reg);

    // One extra bit so count = all-ones is reachable without the compare wrapping.
    assign cnt_inc    = {1'b0, cnt_reg} + {{CNTW{1'b0}}, 1'b1};
    assign cnt_hit    = (cnt_inc == {1'b0, count});
    assign count_zero = (count == '0);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        trig_next  = 1'b0;
        if (!enable) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_next = WAITA;
                end
                WAITA: begin
                    if (ma) begin
                        if (count_zero) begin
                            state_next = FIRED;
                            trig_next  = 1'b1;
                        end else begin
                            state_next = WAITB;
                            cnt_next   = '0;
                        end
                    end
                end
                WAITB: begin
                    if (evb) begin
                        // Saturate rather than wrap if count is lowered while armed.
                        cnt_next = cnt_inc[CNTW] ? cnt_reg : cnt_inc[CNTW-1:0];
                        if (cnt_hit) begin
                            state_next = FIRED;
                            trig_next  = 1'b1;
                        end
                    end
                end
                default: begin
                    state_next = state_reg;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            din_reg     <= '0;
            dout_reg    <= '0;
            mb_prev_reg <= 1'b0;
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            trig_reg    <= 1'b0;
        end else begin
            din_reg     <= indata;
            dout_reg    <= din_reg;
            mb_prev_reg <= mb;
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            trig_reg    <= trig_next;
        end
    end

    assign trigger = trig_reg;
    assign dataout = dout_reg;
    assign state   = state_reg;

endmodule
